// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC generation, imem read issue, Fetch/Decode presentation with stall hold and branch redirect.
// Latency: one cycle from imem read to presentation; redirect costs exactly one bubble.
// Backpressure: stall parks the presented instruction in a hold register and pauses reads; redirect overrides stall.
module instruction_fetch_unit #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 20,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 20'h00000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_rd_en,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   instr_valid,
  output logic [15:0]            accepted_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q;
  logic [PC_WIDTH-1:0]    req_pc_q;
  logic                   outstanding_q;
  logic                   hold_valid_q;
  logic [INSTR_WIDTH-1:0] hold_instr_q;
  logic [PC_WIDTH-1:0]    hold_pc_q;
  logic [PC_WIDTH-1:0]    last_pc_q;
  logic [PC_WIDTH-1:0]    last_addr_q;

  logic                   rd_req;
  logic [PC_WIDTH-1:0]    rd_addr;
  logic                   capture;
  logic                   clear_hold;
  logic                   in_hold;
  logic                   squash;
  logic                   accept;
  logic [PC_WIDTH-1:0]    pres_pc;
  logic [INSTR_WIDTH-1:0] pres_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_req     = 1'b0;
    rd_addr    = fetch_pc_q;
    capture    = 1'b0;
    clear_hold = 1'b0;
    case (state_q)
      IDLE: begin
        rd_req  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          rd_req  = 1'b1;
          rd_addr = redirect_target;
        end else if (!stall) begin
          rd_req = 1'b1;
        end else if (outstanding_q) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Leaving HOLD always restarts the read stream so the next word lands without a bubble.
        if (redirect) begin
          rd_req     = 1'b1;
          rd_addr    = redirect_target;
          clear_hold = 1'b1;
          state_d    = RUN;
        end else if (!stall) begin
          rd_req     = 1'b1;
          clear_hold = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_hold    = (state_q == HOLD);
  assign pres_pc    = in_hold ? hold_pc_q : req_pc_q;
  assign pres_instr = in_hold ? hold_instr_q : imem_rdata;
  assign squash     = redirect && (state_q != IDLE);

  assign instr_valid     = (hold_valid_q | outstanding_q) & ~squash;
  assign instruction_out = instr_valid ? pres_instr : NOP_INSTR;
  assign pc_out          = instr_valid ? pres_pc : last_pc_q;
  assign accept          = instr_valid & ~stall & ~redirect;

  // IDLE would request while reset is still asserted; keep the strobe quiet until release.
  assign imem_rd_en = rd_req & ~reset;
  assign imem_addr  = imem_rd_en ? rd_addr : last_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q     <= RESET_PC;
      req_pc_q       <= RESET_PC;
      outstanding_q  <= 1'b0;
      hold_valid_q   <= 1'b0;
      hold_instr_q   <= NOP_INSTR;
      hold_pc_q      <= '0;
      last_pc_q      <= '0;
      last_addr_q    <= RESET_PC;
      accepted_count <= 16'h0000;
    end else begin
      outstanding_q <= rd_req;
      if (rd_req) begin
        req_pc_q    <= rd_addr;
        fetch_pc_q  <= rd_addr + PC_WIDTH'(1);
        last_addr_q <= rd_addr;
      end
      if (capture) begin
        hold_valid_q <= 1'b1;
        hold_instr_q <= imem_rdata;
        hold_pc_q    <= req_pc_q;
      end else if (clear_hold) begin
        hold_valid_q <= 1'b0;
      end
      if (instr_valid) begin
        last_pc_q <= pres_pc;
      end
      if (accept && (accepted_count != 16'hFFFF)) begin
        accepted_count <= accepted_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed test-plan steps then random stall/redirect traffic,
// checked against a presentation-order model (which PC is shown next, what gets counted).
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_target;
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [19:0] imem_rdata;
  logic [15:0] pc_out;
  logic [19:0] instruction_out;
  logic        instr_valid;
  logic [15:0] accepted_count;

  int vectors     = 0;
  int miscompares = 0;

  // Model: the next PC decode should see, whether anything is due, and the history-held outputs.
  logic        m_idle;
  logic        m_valid;
  logic [15:0] m_pc;
  logic [15:0] m_last_pc;
  logic [15:0] m_last_addr;
  int          m_count;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .PC_WIDTH    (16),
    .INSTR_WIDTH (20),
    .RESET_PC    (16'h0000),
    .NOP_INSTR   (20'h00000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rd_en      (imem_rd_en),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .instr_valid     (instr_valid),
    .accepted_count  (accepted_count)
  );

  // Synchronous instruction memory holding 20'h10000 + address.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 20'h10000 + {4'h0, imem_addr};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle      = 1'b1;
    m_valid     = 1'b0;
    m_pc        = 16'h0000;
    m_last_pc   = 16'h0000;
    m_last_addr = 16'h0000;
    m_count     = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instr_valid"}, instr_valid, 0);
    chk({tag, "_pc_out"}, pc_out, 0);
    chk({tag, "_instruction_out"}, instruction_out, 0);
    chk({tag, "_imem_rd_en"}, imem_rd_en, 0);
    chk({tag, "_accepted_count"}, accepted_count, 0);
  endtask

  // One clock cycle: drive just after the rising edge, check on the falling edge.
  task automatic step(input logic s, input logic r, input logic [15:0] t);
    logic        ev;
    logic        er;
    logic        nvalid;
    logic [15:0] epc;
    logic [15:0] npc;
    logic [15:0] eaddr;
    logic [19:0] einstr;
    stall           = s;
    redirect        = r;
    redirect_target = t;
    #4;
    ev     = m_valid & ~r;
    epc    = ev ? m_pc : m_last_pc;
    einstr = ev ? (20'h10000 + {4'h0, m_pc}) : 20'h00000;
    er     = m_idle | r | ~s;
    if (m_idle) begin
      nvalid = 1'b1; npc = 16'h0000;
    end else if (r) begin
      nvalid = 1'b1; npc = t;
    end else if (m_valid && s) begin
      nvalid = 1'b1; npc = m_pc;
    end else if (m_valid) begin
      nvalid = 1'b1; npc = m_pc + 16'd1;
    end else begin
      nvalid = 1'b0; npc = m_pc;
    end
    eaddr = er ? npc : m_last_addr;
    chk("instr_valid", instr_valid, ev);
    chk("pc_out", pc_out, epc);
    chk("instruction_out", instruction_out, einstr);
    chk("imem_rd_en", imem_rd_en, er);
    chk("imem_addr", imem_addr, eaddr);
    chk("accepted_count", accepted_count, m_count);
    if (ev) m_last_pc = m_pc;
    if (er) m_last_addr = npc;
    if (ev && !s) m_count = (m_count == 65535) ? 65535 : m_count + 1;
    m_valid = nvalid;
    m_pc    = npc;
    m_idle  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 16'h0000;
    reset           = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    chk_reset("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Streaming from reset: idle cycle, then pc 0..4.
    step(1'b0, 1'b0, 16'h0);
    repeat (5) step(1'b0, 1'b0, 16'h0);
    // Three-cycle stall on pc 5, then 6..8.
    repeat (3) step(1'b1, 1'b0, 16'h0);
    repeat (4) step(1'b0, 1'b0, 16'h0);
    // Redirect at pc 9 to 2, stream 2..6.
    step(1'b0, 1'b1, 16'd2);
    repeat (5) step(1'b0, 1'b0, 16'h0);
    // Hold pc 7, then redirect+stall together to 20.
    repeat (2) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'd20);
    repeat (2) step(1'b0, 1'b0, 16'h0);
    // Wrap through FFFF.
    step(1'b0, 1'b1, 16'hFFFF);
    repeat (3) step(1'b0, 1'b0, 16'h0);
    // Enter HOLD, then async reset between edges.
    repeat (2) step(1'b1, 1'b0, 16'h0);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk_reset("async");
    @(posedge clk);
    #1;
    chk_reset("async_held");
    reset = 1'b0;
    stall = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 16'h0);
    repeat (4) step(1'b0, 1'b0, 16'h0);

    // Random traffic.
    repeat (400) begin
      logic        rs;
      logic        rr;
      logic [15:0] rt;
      rs = ($urandom_range(99) < 30);
      rr = ($urandom_range(99) < 10);
      rt = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      step(rs, rr, rt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
